// File: rtl/fpu_fcsr_unit.sv
// fpu_fcsr_unit: FP control/status register unit.
// Holds per-instruction exception flags in an in-order pending queue until the
// instruction retires, accrues them into sticky fflags, and services the
// fflags/frm/fcsr CSR accesses with swap (read-before-write) semantics.
// Optional build macro: FCSR_RM_CHECK_EN adds the registered rm_illegal output.
module fpu_fcsr_unit #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flag_valid,
    output logic                       flag_ready,
    input  logic [4:0]                 flag_bits,
    input  logic                       retire_fp,
    input  logic                       flush,
    input  logic                       csr_valid,
    input  logic [1:0]                 csr_op,
    input  logic [11:0]                csr_addr,
    input  logic [31:0]                csr_wdata,
    output logic                       csr_hit,
    output logic [31:0]                csr_rdata,
    output logic                       csr_busy,
    output logic [4:0]                 fflags,
    output logic [2:0]                 frm,
    output logic [$clog2(DEPTH+1)-1:0] pend_count
`ifdef FCSR_RM_CHECK_EN
    ,
    output logic                       rm_illegal
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [11:0] ADDR_FFLAGS = 12'h001;
    localparam logic [11:0] ADDR_FRM    = 12'h002;
    localparam logic [11:0] ADDR_FCSR   = 12'h003;

    logic [4:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [4:0]    r_fflags;
    logic [2:0]    r_frm;

    logic       w_push;
    logic       w_pop;
    logic [4:0] w_retire_flags;
    logic [4:0] w_eff;
    logic       w_csr_wr;
    logic [7:0] w_operand;
    logic [7:0] w_csr_new;
    logic [4:0] w_fflags_next;
    logic [2:0] w_frm_next;
    logic       w_unused_wdata;

    // Apply a CSR read-modify-write operation bitwise over the packed {frm, fflags} image.
    function automatic logic [7:0] csr_apply(input logic [1:0] op,
                                             input logic [7:0] old_v,
                                             input logic [7:0] w);
        case (op)
            OP_RW:   csr_apply = w;
            OP_RS:   csr_apply = old_v | w;
            OP_RC:   csr_apply = old_v & ~w;
            default: csr_apply = old_v;
        endcase
    endfunction

    // Circular pointer advance wrapping at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign w_unused_wdata = ^csr_wdata[31:8];

    assign flag_ready     = (r_count < DEPTH_C);
    assign w_push         = flag_valid && flag_ready;
    assign w_pop          = retire_fp && (r_count != '0);
    assign w_retire_flags = w_pop ? r_mem[r_rptr] : 5'b0;
    // The CSR access is ordered after the retiring instruction, so it sees its flags.
    assign w_eff          = r_fflags | w_retire_flags;

    assign csr_hit  = csr_valid && ((csr_addr == ADDR_FFLAGS) ||
                                    (csr_addr == ADDR_FRM)    ||
                                    (csr_addr == ADDR_FCSR));
    assign w_csr_wr = csr_hit && (csr_op != 2'b00);
    assign csr_busy = (r_count > CW'(1)) || ((r_count == CW'(1)) && !retire_fp);

    assign fflags     = r_fflags;
    assign frm        = r_frm;
    assign pend_count = r_count;

    // Read mux returns the pre-write value, including flags retiring this cycle.
    always_comb begin
        csr_rdata = 32'b0;
        case (csr_addr)
            ADDR_FFLAGS: csr_rdata = {27'b0, w_eff};
            ADDR_FRM:    csr_rdata = {29'b0, r_frm};
            ADDR_FCSR:   csr_rdata = {24'b0, r_frm, w_eff};
            default:     csr_rdata = 32'b0;
        endcase
    end

    // Align the write operand into the {frm, fflags} image and select the fields the address owns.
    always_comb begin
        w_operand = {3'b0, csr_wdata[4:0]};
        if (csr_addr == ADDR_FRM) begin
            w_operand = {csr_wdata[2:0], 5'b0};
        end else if (csr_addr == ADDR_FCSR) begin
            w_operand = csr_wdata[7:0];
        end
        w_csr_new     = csr_apply(csr_op, {r_frm, w_eff}, w_operand);
        w_fflags_next = w_eff;
        w_frm_next    = r_frm;
        if (w_csr_wr) begin
            if (csr_addr != ADDR_FRM) begin
                w_fflags_next = w_csr_new[4:0];
            end
            if (csr_addr != ADDR_FFLAGS) begin
                w_frm_next = w_csr_new[7:5];
            end
        end
    end

    // Queue storage: contents are don't-care after reset/flush, so no reset here.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= flag_bits;
        end
    end

    // Control state: pointers, occupancy, and the architectural fflags/frm registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_fflags <= 5'b0;
            r_frm    <= 3'b0;
        end else begin
            r_fflags <= w_fflags_next;
            r_frm    <= w_frm_next;
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= ptr_inc(r_wptr);
                end
                if (w_pop) begin
                    r_rptr <= ptr_inc(r_rptr);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef FCSR_RM_CHECK_EN
    logic r_rm_illegal;

    // Reserved rounding-mode encodings flagged one cycle after frm is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rm_illegal <= 1'b0;
        end else begin
            r_rm_illegal <= (w_frm_next >= 3'b101);
        end
    end

    assign rm_illegal = r_rm_illegal;
`endif

endmodule

// File: doc/fpu_fcsr_unit.md
# fpu_fcsr_unit

Floating-point control/status register unit that sits directly downstream of the FPU exception-flag generator. It buffers each completed FP operation's 5-bit `{NV,DZ,OF,UF,NX}` flag vector in an in-order pending queue, ORs the flags into the sticky `fflags` field only when the owning instruction retires, and discards them on a pipeline flush. It also services the RISC-V `fflags` (0x001), `frm` (0x002) and `fcsr` (0x003) CSR accesses, and drives the dynamic rounding mode back into the FPU.

## Interface
- `DEPTH`, 4, number of pending flag entries; legal values 2..16.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flag_valid`  in  1  FPU completion carries a flag vector.
- `flag_ready`  out  1  queue can accept a vector; equals `pend_count < DEPTH`.
- `flag_bits`  in  5  `{NV,DZ,OF,UF,NX}` from the exception-flag stage.
- `retire_fp`  in  1  oldest pending FP instruction commits.
- `flush`  in  1  discard all pending entries.
- `csr_valid`  in  1  CSR access this cycle.
- `csr_op`  in  2  00 read-only, 01 RW, 10 RS (set), 11 RC (clear).
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  32  write/set/clear operand.
- `csr_hit`  out  1  `csr_valid` and `csr_addr` ∈ {0x001, 0x002, 0x003}.
- `csr_rdata`  out  32  read value; combinational.
- `csr_busy`  out  1  queue still holds entries after this cycle's retire.
- `fflags`  out  5  sticky accrued flags.
- `frm`  out  3  dynamic rounding mode.
- `pend_count`  out  $clog2(DEPTH+1)  occupied entries.
- `rm_illegal`  out  1  present only under the macro (see Configuration).

## Operation
- Queue: circular buffer with write/read pointers that wrap modulo DEPTH. A push occurs when `flag_valid && flag_ready`. A pop occurs when `retire_fp && pend_count != 0`. `retire_fp` on an empty queue is ignored.
- Push and pop in the same cycle: both happen and the count is unchanged. When full, `flag_ready` is 0 even if a pop occurs that cycle (no pass-through).
- `retire_flags` = head entry if a pop occurs this cycle, else 0.
- Flush: the same-cycle pop still commits its head entry. Every other entry is discarded, a same-cycle push is dropped, and both pointers and the count return to 0.
- Effective flags: `eff = fflags | retire_flags`. The CSR access is ordered after the retiring instruction.
- Read data (zero-extended to 32 bits):
  - 0x001 → `eff`
  - 0x002 → `frm`
  - 0x003 → `{frm, eff}`
  - any other address → 0
- CSR update, applied only when `csr_hit` and `csr_op != 00`. Operand `w` is `csr_wdata[4:0]` for fflags, `csr_wdata[2:0]` for frm, and `csr_wdata[7:0]` for fcsr.
  - RW: new = w
  - RS: new = old | w
  - RC: new = old & ~w
- For fcsr, `w[7:5]` updates `frm` and `w[4:0]` updates `fflags`. Bits above the field are ignored.
- When there is no CSR write to `fflags`, next `fflags = eff`.
- `csr_busy = (pend_count > 1) || (pend_count == 1 && !retire_fp)`. This is advisory only; the unit executes the CSR access regardless.

## Timing
- Reset values: `fflags = 0`, `frm = 000`, `pend_count = 0`, `flag_ready = 1`, `csr_busy = 0`, `rm_illegal = 0`. Pointers are 0 and queue contents are don't-care.
- `rst` takes priority over `flush`, `retire_fp` and CSR writes. Reset during a partially filled queue empties it in one cycle.
- A pushed entry becomes retirable in the cycle after the push; the queue has 1-cycle latency.
- A retired flag is visible on `fflags` one cycle after `retire_fp`. It is visible on `csr_rdata` in the same cycle via `eff`.
- A CSR write is visible on `fflags`/`frm` the next cycle. `csr_rdata` always returns the pre-write value (swap semantics).
- `csr_rdata`, `csr_hit`, `flag_ready` and `csr_busy` are combinational from the current state and inputs. All other outputs are registered.

## Configuration
- `FCSR_RM_CHECK_EN` defined: the `rm_illegal` port exists and is driven as `frm ∈ {101, 110, 111}`. The output is registered alongside `frm`, so it is 0 from reset and updates in the cycle after an `frm` write.
- `FCSR_RM_CHECK_EN` undefined: the port and its logic are absent, and any `frm` value is stored without a check.

## Test plan
- Reset, then push 5'b00001 and 5'b10000 and retire twice → `fflags` = 00001 after the first retire and 10001 after the second; `pend_count` goes 2→1→0.
- Fill DEPTH=4 entries → `flag_ready` = 0. In the next cycle assert push+retire together → push refused, `pend_count` = 3; next cycle `flag_ready` = 1.
- Hold 3 entries, then flush together with retire of head 5'b00100 while pushing 5'b01000 → `fflags` = 00100, `pend_count` = 0, the 5'b01000 vector is lost.
- With `fflags` = 00011, CSR RS to 0x003 with wdata 0x0000_0084 in the same cycle as retiring 5'b10000 → `csr_rdata` = 0x13; next cycle `frm` = 100, `fflags` = 10111.
- CSR RC to 0x001 with wdata 0x1F → `fflags` = 0. CSR RW to 0x002 with wdata 0xFFFF_FFF5 → `frm` = 101, and `rm_illegal` = 1 next cycle when `FCSR_RM_CHECK_EN` is defined.
- CSR read of 0x004 → `csr_hit` = 0, `csr_rdata` = 0, no state change.
